// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the buffered UART transmitter:
//   - tx_state_t       : transmitter FSM state encoding
//   - PARITY_*         : parity mode constants (none / odd / even)
//   - cycles_per_bit() : clock cycles per line bit (integer division)
//   - parity_of()      : parity bit for a zero-extended data word
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

  // Zero padding does not change the ones count, so callers may pass any
  // payload width up to 9 bits zero-extended.
  function automatic logic parity_of(input logic [8:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// uart_tx_buffered_if
// Write-side handshake of the buffered UART transmitter.
//   tx_valid : producer offers tx_data this cycle
//   tx_ready : transmitter FIFO can take a word this cycle
//   tx_data  : word to transmit (PAYLOAD_BITS wide)
//   tx_level : current number of FIFO entries
// master = producer side, slave = transmitter side.
interface uart_tx_buffered_if #(
  parameter int PAYLOAD_BITS = 8,
  parameter int FIFO_DEPTH   = 16
);

  logic                          tx_valid;
  logic                          tx_ready;
  logic [PAYLOAD_BITS-1:0]       tx_data;
  logic [$clog2(FIFO_DEPTH):0]   tx_level;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready,
    input  tx_level
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    output tx_level
  );

endinterface

// File: rtl/uart_fifo.sv
// uart_fifo
// Synchronous FIFO with registered pointers and level.
//   clk, resetn : clock, asynchronous active-low reset
//   push        : write wr_data (ignored when full, even with a pop)
//   pop         : drop the head entry (ignored when empty)
//   wr_data     : word to write
//   rd_data     : head entry; a pushed word appears one cycle after its edge
//   full, empty : status flags
//   level       : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          wr_data,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // The head is read straight out of storage; there is no bypass from
  // wr_data, so a word only becomes visible after its push edge.
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
// UART transmitter with a transmit FIFO in front of the serialiser.
//   clk          : system clock, rising edge
//   resetn       : asynchronous active-low reset; aborts any frame in flight
//   tx_if        : slave side of the write handshake (valid/ready/data/level)
//   uart_txd     : registered serial line, idles high
//   uart_tx_busy : high while a frame is on the line or the FIFO holds words
// Frame: start(0), PAYLOAD_BITS data LSB first, optional parity,
// STOP_BITS stop bits(1); each line bit lasts CLK_HZ/BIT_RATE cycles.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 115200,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic              clk,
  input  logic              resetn,
  uart_tx_buffered_if.slave tx_if,
  output logic              uart_txd,
  output logic              uart_tx_busy
);

  localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT) + 1;
  localparam int LVL_W          = $clog2(FIFO_DEPTH) + 1;

  tx_state_t               state;
  logic [CNT_W-1:0]        cycle_cnt;
  logic [3:0]              bit_cnt;
  logic [PAYLOAD_BITS-1:0] shift_reg;
  logic                    parity_q;
  logic                    busy_q;
  logic                    ready_en;

  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [PAYLOAD_BITS-1:0] fifo_rd_data;
  logic [LVL_W-1:0]        fifo_level;

  logic                    bit_end;
  logic                    last_data;
  logic                    last_stop;
  logic                    line_bit;

  // ready_en is cleared by reset so tx_ready reads low while resetn is low
  // and rises on the first clock edge after release. fifo_full is exactly
  // the level having reached FIFO_DEPTH.
  assign tx_if.tx_ready = ready_en && !fifo_full;
  assign tx_if.tx_level = fifo_level;
  assign fifo_push      = tx_if.tx_valid && tx_if.tx_ready;

  assign bit_end   = (cycle_cnt == CNT_W'(CYCLES_PER_BIT - 1));
  assign last_data = (bit_cnt == 4'(PAYLOAD_BITS - 1));
  assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));

  // A word is taken either from IDLE or on the last cycle of the final stop
  // bit, which is what makes consecutive frames abut with no idle gap.
  assign fifo_pop = !fifo_empty &&
                    ((state == ST_IDLE) || (state == ST_STOP && bit_end && last_stop));

  // busy_q tracks the one-cycle lag of the registered line, so busy stays
  // high through the final stop-bit cycle actually on the wire.
  assign uart_tx_busy = (state != ST_IDLE) || busy_q || !fifo_empty;

  uart_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (tx_if.tx_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    line_bit = 1'b1;
    case (state)
      ST_START:  line_bit = 1'b0;
      ST_DATA:   line_bit = shift_reg[0];
      ST_PARITY: line_bit = parity_q;
      default:   line_bit = 1'b1;
    endcase
  end

  // The line register follows the state one cycle later, so the start bit
  // appears on the second edge after a word is accepted into an idle
  // transmitter, and every state's bit period maps onto the line intact.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      cycle_cnt <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      parity_q  <= 1'b0;
      busy_q    <= 1'b0;
      ready_en  <= 1'b0;
      uart_txd  <= 1'b1;
    end else begin
      ready_en <= 1'b1;
      uart_txd <= line_bit;
      busy_q   <= (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          cycle_cnt <= '0;
          bit_cnt   <= '0;
          if (fifo_pop) begin
            shift_reg <= fifo_rd_data;
            parity_q  <= parity_of(9'(fifo_rd_data), PARITY);
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            cycle_cnt <= '0;
            bit_cnt   <= '0;
            state     <= ST_DATA;
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            cycle_cnt <= '0;
            shift_reg <= shift_reg >> 1;
            if (last_data) begin
              bit_cnt <= '0;
              state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            cycle_cnt <= '0;
            bit_cnt   <= '0;
            state     <= ST_STOP;
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            cycle_cnt <= '0;
            if (last_stop) begin
              bit_cnt <= '0;
              if (fifo_pop) begin
                shift_reg <= fifo_rd_data;
                parity_q  <= parity_of(9'(fifo_rd_data), PARITY);
                state     <= ST_START;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end
        default: begin
          cycle_cnt <= '0;
          bit_cnt   <= '0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
